// File: rtl/seven_segment_scanner_pkg.sv
// Shared widths and the digit-select helper for the seven-segment scan driver.
package seg_pkg;

  localparam int SEG_NIBBLE_W   = 4;
  localparam int SEG_DIGITS_MAX = 8;

  // Active-low one-hot select; bits at or above 'digits' stay inactive.
  function automatic logic [SEG_DIGITS_MAX-1:0] seg_onehot_n(input int idx, input int digits);
    logic [SEG_DIGITS_MAX-1:0] m;
    m = '1;
    for (int i = 0; i < SEG_DIGITS_MAX; i++) begin
      if ((i == idx) && (i < digits)) begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Valid/ready load port carrying a packed hex value (nibble k -> digit k) into the scanner.
interface seg_scan_if import seg_pkg::*; #(
  parameter int DIGITS = 8
);

  logic [SEG_NIBBLE_W*DIGITS-1:0] data_in;
  logic                           data_valid;
  logic                           data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/seven_segment_scanner_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and wraps; tick marks the last count of a slot.
module seg_scan_prescaler import seg_pkg::*; #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic             w_last;

  assign w_last = (r_div_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign tick = w_last;

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display scanner: double-buffered valid/ready load, commit only at frame wrap,
// outputs registered one cycle after idx/shown; SEG_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
module seven_segment_scanner import seg_pkg::*; #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_scan_if.slave               s_in,
  output logic [SEG_NIBBLE_W-1:0] digit_data,
  output logic                    seg_blank_n,
  output logic [DIGITS-1:0]       digit_sel_n,
  output logic                    frame_done
);

  localparam int               DW       = SEG_NIBBLE_W * DIGITS;
  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic                      w_tick;
  logic                      w_wrap;
  logic                      w_accept;
  logic                      w_data_ready;
  logic                      w_lit;
  logic [DW-1:0]             w_data_in;
  logic [SEG_NIBBLE_W-1:0]   w_nibble;
  logic [SEG_DIGITS_MAX-1:0] w_mask;

  logic [IDX_W-1:0]          r_idx;
  logic [DW-1:0]             r_pend;
  logic [DW-1:0]             r_shown;
  logic                      r_pending;
  logic                      r_rst_q;
  logic                      r_slot_first;
  logic [SEG_NIBBLE_W-1:0]   r_digit_data;
  logic                      r_blank_n;
  logic [DIGITS-1:0]         r_sel_n;
  logic                      r_frame_done;

  seg_scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_wrap    = w_tick && (r_idx == IDX_LAST);
  assign w_data_in = s_in.data_in;

  // Ready is held low for the first cycle after a reset edge, then tracks the empty pend buffer.
  assign w_data_ready    = !r_pending && !r_rst_q;
  assign s_in.data_ready = w_data_ready;
  assign w_accept        = s_in.data_valid && w_data_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_rst_q      <= 1'b1;
      r_slot_first <= 1'b1;
    end else begin
      r_rst_q      <= 1'b0;
      r_slot_first <= w_tick;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // A new value reaches 'shown' only on the wrap, so one frame never mixes two values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_shown   <= '0;
      r_pending <= 1'b0;
    end else if (w_wrap) begin
      if (r_pending) begin
        r_shown   <= r_pend;
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_shown <= w_data_in;
      end
    end else if (w_accept) begin
      r_pend    <= w_data_in;
      r_pending <= 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  function automatic logic [IDX_W-1:0] top_nonzero(input logic [DW-1:0] v);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[k*SEG_NIBBLE_W +: SEG_NIBBLE_W] != '0) begin
        pos = IDX_W'(k);
      end
    end
    return pos;
  endfunction

  // Digit 0 always satisfies this, so an all-zero value still shows a single 0.
  assign w_lit = (r_idx <= top_nonzero(r_shown));
`else
  assign w_lit = 1'b1;
`endif

  assign w_nibble = SEG_NIBBLE_W'(r_shown >> (SEG_NIBBLE_W * int'(r_idx)));
  assign w_mask   = seg_onehot_n(int'(r_idx), DIGITS);

  // r_slot_first is high in the first cycle of each internal slot, so the blank lines up with the select change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit_data <= '0;
      r_sel_n      <= '1;
      r_blank_n    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_digit_data <= w_nibble;
      r_sel_n      <= w_mask[DIGITS-1:0];
      r_blank_n    <= !r_slot_first && w_lit;
      r_frame_done <= w_wrap;
    end
  end

  assign digit_data  = r_digit_data;
  assign digit_sel_n = r_sel_n;
  assign seg_blank_n = r_blank_n;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (DIGITS=4, SCAN_DIV=4) with a frame scoreboard.
module tb_seven_segment_scanner;
  import seg_pkg::*;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct {
    int          start;
    logic [15:0] val;
  } frame_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        digit_data;
  logic              seg_blank_n;
  logic [DIGITS-1:0] digit_sel_n;
  logic              frame_done;

  seg_scan_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scanner #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in        (bus),
    .digit_data  (digit_data),
    .seg_blank_n (seg_blank_n),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  int          checks  = 0;
  int          passed  = 0;
  int          cyc     = 0;
  frame_t      sb[$];
  logic [15:0] cur_val = '0;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle forward, then compare all display outputs against the frame timeline model.
  task automatic tick_check();
    frame_t     f;
    int         slot;
    logic [3:0] exp_sel;
    logic [3:0] exp_dat;
    logic       exp_blank;
    logic       exp_fd;
    step();
    if (sb.size() > 0 && sb[0].start == cyc) begin
      f       = sb.pop_front();
      cur_val = f.val;
    end
    slot          = ((cyc - 1) / SCAN_DIV) % DIGITS;
    exp_sel       = 4'hF;
    exp_sel[slot] = 1'b0;
    exp_dat       = 4'((cur_val >> (4 * slot)) & 16'hF);
    exp_blank     = ((cyc - 1) % SCAN_DIV) != 0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin : lzb_model
      int top;
      top = 0;
      for (int k = 0; k < DIGITS; k++) begin
        if (((cur_val >> (4 * k)) & 16'hF) != 16'h0) top = k;
      end
      if (slot > top) exp_blank = 1'b0;
    end
`endif
    exp_fd = (cyc % FRAME) == 0;
    checks++;
    if (digit_sel_n !== exp_sel) $display("FAIL sel cyc=%0d got %h want %h", cyc, digit_sel_n, exp_sel);
    else passed++;
    checks++;
    if (digit_data !== exp_dat) $display("FAIL data cyc=%0d got %h want %h", cyc, digit_data, exp_dat);
    else passed++;
    checks++;
    if (seg_blank_n !== exp_blank) $display("FAIL blank_n cyc=%0d got %b want %b", cyc, seg_blank_n, exp_blank);
    else passed++;
    checks++;
    if (frame_done !== exp_fd) $display("FAIL frame_done cyc=%0d got %b want %b", cyc, frame_done, exp_fd);
    else passed++;
  endtask

  // Holds data_valid until accepted; the value is expected from the frame after the next wrap.
  task automatic load(input logic [15:0] v, output int acc_cyc);
    int n;
    int w;
    n = 0;
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    while (bus.data_ready !== 1'b1 && n < 3 * FRAME) begin
      tick_check();
      n++;
    end
    checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL load_timeout value=%h ready=%b want 1", v, bus.data_ready);
    else passed++;
    acc_cyc = cyc;
    w = cyc + ((FRAME - 1) - (cyc % FRAME));
    sb.push_back('{start: w + 2, val: v});
    tick_check();
    bus.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    step();
    step();
    checks++;
    if (digit_sel_n !== 4'hF) $display("FAIL rst_sel got %h want f", digit_sel_n); else passed++;
    checks++;
    if (digit_data !== 4'h0) $display("FAIL rst_data got %h want 0", digit_data); else passed++;
    checks++;
    if (seg_blank_n !== 1'b0) $display("FAIL rst_blank got %b want 0", seg_blank_n); else passed++;
    checks++;
    if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", frame_done); else passed++;
    checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", bus.data_ready); else passed++;
    rst_n = 1'b1;
    step();
    cyc     = 1;
    cur_val = '0;
    sb.delete();
    checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL rel_ready got %b want 1", bus.data_ready); else passed++;
    checks++;
    if (digit_sel_n !== 4'hE) $display("FAIL rel_sel got %h want e", digit_sel_n); else passed++;
    checks++;
    if (seg_blank_n !== 1'b0) $display("FAIL rel_blank got %b want 0", seg_blank_n); else passed++;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 32; i++) tick_check();
  endtask

  task automatic test_load_midframe();
    int a;
    int w;
    while (cyc % FRAME != 4) tick_check();
    load(16'h1A2F, a);
    checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL ready_after_load got %b want 0", bus.data_ready); else passed++;
    w = a + ((FRAME - 1) - (a % FRAME));
    while (cyc < w) tick_check();
    checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL ready_on_wrap got %b want 0", bus.data_ready); else passed++;
    tick_check();
    checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL ready_after_wrap got %b want 1", bus.data_ready); else passed++;
    for (int i = 0; i < 2 * FRAME; i++) tick_check();
  endtask

  task automatic test_back_to_back();
    int a1;
    int a2;
    int w1;
    while (cyc % FRAME != 6) tick_check();
    load(16'h1234, a1);
    w1 = a1 + ((FRAME - 1) - (a1 % FRAME));
    load(16'h5678, a2);
    checks++;
    if (a2 != w1 + 1) $display("FAIL second_accept_cyc got %0d want %0d", a2, w1 + 1); else passed++;
    for (int i = 0; i < 3 * FRAME; i++) tick_check();
  endtask

  task automatic test_bypass();
    int a;
    while (cyc % FRAME != FRAME - 1) tick_check();
    load(16'hBEEF, a);
    checks++;
    if (a % FRAME != FRAME - 1) $display("FAIL bypass_accept_phase got %0d want %0d", a % FRAME, FRAME - 1);
    else passed++;
    checks++;
    if (bus.data_ready !== 1'b1) $display("FAIL bypass_pending got ready=%b want 1", bus.data_ready); else passed++;
    for (int i = 0; i < 2 * FRAME; i++) tick_check();
  endtask

  task automatic test_mid_reset();
    int a;
    while (cyc % FRAME != 5) tick_check();
    load(16'h9999, a);
    checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL pend_before_reset got ready=%b want 0", bus.data_ready); else passed++;
    tick_check();
    rst_n = 1'b0;
    step();
    checks++;
    if (digit_sel_n !== 4'hF) $display("FAIL mid_rst_sel got %h want f", digit_sel_n); else passed++;
    checks++;
    if (digit_data !== 4'h0) $display("FAIL mid_rst_data got %h want 0", digit_data); else passed++;
    checks++;
    if (seg_blank_n !== 1'b0) $display("FAIL mid_rst_blank got %b want 0", seg_blank_n); else passed++;
    checks++;
    if (bus.data_ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", bus.data_ready); else passed++;
    rst_n = 1'b1;
    step();
    cyc     = 1;
    cur_val = '0;
    sb.delete();
    checks++;
    if (digit_sel_n !== 4'hE) $display("FAIL mid_rel_sel got %h want e", digit_sel_n); else passed++;
    for (int i = 0; i < 3 * FRAME; i++) tick_check();
  endtask

`ifdef SEG_LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    int a;
    load(16'h0030, a);
    for (int i = 0; i < 2 * FRAME; i++) tick_check();
    load(16'h0000, a);
    for (int i = 0; i < 2 * FRAME; i++) tick_check();
  endtask
`endif

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    test_reset();
    test_idle();
    test_load_midframe();
    test_back_to_back();
    test_bypass();
    test_mid_reset();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
